odo_round_sequencer: RTL and testbench
======================================

Name: odo_round_sequencer

Overview:
- Sequences the Odo round-key ROM (odo_get_round_key2) for one hash-round pipeline.
- Steps the 4-bit period index modulo KEY_PERIOD across NUM_ROUNDS rounds.
- Compensates for the ROM's one-cycle registered latency.
- Presents a valid/ready round stream so the round datapath consumes exactly one key per accepted round, at one round per cycle when unstalled.

Parameters:
- NUM_ROUNDS, 84: rounds per job (legal range 1..2^RIDX_W).
- KEY_PERIOD, 10: round-key table length; period wraps at KEY_PERIOD-1 -> 0 (legal range 1..16).
- RIDX_W, 7: width of round_idx.

Ports:
- clk  in  1  rising-edge clock, shared with the key ROM
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request, sampled only in IDLE
- abort  in  1  cancel current job; dominates start and fire
- dp_ready  in  1  datapath accepts the current round/key this cycle
- period  out  4  drives ROM period input (combinational lookahead, see Behaviour)
- round_valid  out  1  ROM key output corresponds to round_idx
- round_idx  out  RIDX_W  current round number, 0..NUM_ROUNDS-1
- round_last  out  1  round_valid and round_idx==NUM_ROUNDS-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last round is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, round counter=0, period counter=0. All outputs 0: period=0, round_valid=0, round_idx=0, round_last=0, busy=0, done=0. Outputs remain at reset values for the whole time rst_n is low.
- Internal registers: state, r (RIDX_W bits), p (4 bits, always equal to r mod KEY_PERIOD). No divider; p is maintained by an increment-and-wrap counter.
- Define fire = round_valid & dp_ready & ~abort.
- period output:
  - In RUN, period = fire ? next_p : p, where next_p = (p==KEY_PERIOD-1) ? 0 : p+1.
  - In all other states, period = 0.
  - This gives zero-bubble throughput: on a fire edge the ROM captures key(r+1). On a stall the ROM recaptures key(r), so the key is stable.
  - dp_ready -> period is a combinational path, by design.
- States:
  - IDLE: busy=0. If start & ~abort, go to PRIME with r=0, p=0.
  - PRIME: exactly one cycle. period=0, so the ROM loads key(0). Next state is RUN. If abort, go to IDLE instead.
  - RUN: round_valid=1, round_idx=r, round_last=(r==NUM_ROUNDS-1).
    - On fire with round_last: go to DONE; r and p are unchanged.
    - On fire otherwise: r<=r+1, p<=next_p.
    - No fire (dp_ready=0): hold everything.
    - abort: go to IDLE; r<=0, p<=0; no done.
  - DONE: done=1 for exactly one cycle, busy=1, round_valid=0. Next state is IDLE; r<=0, p<=0. abort in DONE has no effect (done still pulses).
- Latency: start accepted at edge E0. round_valid rises after edge E0+1 (PRIME -> RUN). With dp_ready held at 1, round_valid stays high for NUM_ROUNDS cycles. done is high the cycle after round_last fires. start-to-done = NUM_ROUNDS+2 cycles.
- start while busy (PRIME/RUN/DONE): ignored, not queued. A start in the same cycle as done is also ignored.
- NUM_ROUNDS=1: a single RUN cycle with round_last=1.
- period wrap: after round 9 the period returns to 0. For the default configuration, round r uses key(r mod 10), and round 83 uses key(3).
- Reset asserted mid-job: immediate return to reset values. No done pulse; no residual round_valid after release.

Test Plan:
- Default params, dp_ready=1, start pulse:
  - round_valid high for 84 consecutive cycles, starting 2 cycles after start.
  - ROM key sequence is 3ef,2d9,2d7,229,008,335,091,073,1ce,1c6 repeating.
  - round 83 key = 229 with round_last=1.
  - done pulses once, on the next cycle; busy falls with it.
- Stall: dp_ready=0 for 3 cycles while round_idx=9 (key 1c6):
  - round_idx, key and period (=9) are held.
  - On release, the next cycle shows round_idx=10, key 3ef, with no bubble and no skipped key.
- Random dp_ready (50%) over a full job: the scoreboard sees exactly 84 accepted rounds, each with key(r mod 10), in order.
- abort at round_idx=40 in RUN:
  - Next cycle: IDLE, round_valid=0, no done.
  - A following start yields a fresh job beginning at round 0 / key 3ef.
- start pulsed during RUN and in the done cycle: ignored, no second job. A start one cycle after done launches a new job.
- rst_n low at round_idx=20: all outputs 0 immediately (asynchronously). After release, stays idle until start; no done observed.

Source files
------------

// File: rtl/odo_round_sequencer_if.sv
// odo_round_sequencer_if: job control and round/key stream between a job controller and the round sequencer
interface odo_round_sequencer_if #(parameter int RIDX_W = 7);
    logic              start;
    logic              abort;
    logic              dp_ready;
    logic [3:0]        period;
    logic              round_valid;
    logic [RIDX_W-1:0] round_idx;
    logic              round_last;
    logic              busy;
    logic              done;
    modport master (output start, abort, dp_ready,
                    input  period, round_valid, round_idx, round_last, busy, done);
    modport slave  (input  start, abort, dp_ready,
                    output period, round_valid, round_idx, round_last, busy, done);
endinterface

// File: rtl/odo_round_sequencer.sv
// odo_round_sequencer: steps the Odo round-key ROM period across the rounds of one job and
// presents a valid/ready round stream aligned with the ROM's one-cycle registered latency.
module odo_round_sequencer #(
    parameter int NUM_ROUNDS = 84,
    parameter int KEY_PERIOD = 10,
    parameter int RIDX_W     = 7
) (
    input logic                  clk,
    input logic                  rst_n,
    odo_round_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;
    localparam logic [RIDX_W-1:0] LAST   = RIDX_W'(NUM_ROUNDS - 1);
    localparam logic [3:0]        P_LAST = 4'(KEY_PERIOD - 1);
    state_t            state;
    logic [RIDX_W-1:0] r;
    logic [3:0]        p;
    logic [3:0]        next_p;
    logic              fire;
    logic              round_valid;
    logic              round_last;
    logic              busy;
    logic              done;
    always_comb begin
        fire   = round_valid & bus.dp_ready & ~bus.abort;
        next_p = (p == P_LAST) ? 4'd0 : p + 4'd1;
    end
    // Lookahead: on a fire edge the ROM already captures the next round's key.
    assign bus.period      = (state == RUN) ? (fire ? next_p : p) : 4'd0;
    assign bus.round_valid = round_valid;
    assign bus.round_idx   = r;
    assign bus.round_last  = round_last;
    assign bus.busy        = busy;
    assign bus.done        = done;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            p           <= '0;
            round_valid <= 1'b0;
            round_last  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start && !bus.abort) begin
                    state <= PRIME;
                    r     <= '0;
                    p     <= '0;
                    busy  <= 1'b1;
                end
                PRIME: if (bus.abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    state       <= RUN;
                    round_valid <= 1'b1;
                    round_last  <= (r == LAST);
                end
                RUN: if (bus.abort) begin
                    state       <= IDLE;
                    r           <= '0;
                    p           <= '0;
                    round_valid <= 1'b0;
                    round_last  <= 1'b0;
                    busy        <= 1'b0;
                end else if (fire && round_last) begin
                    state       <= DONE;
                    round_valid <= 1'b0;
                    round_last  <= 1'b0;
                    done        <= 1'b1;
                end else if (fire) begin
                    r          <= r + RIDX_W'(1);
                    p          <= next_p;
                    round_last <= ((r + RIDX_W'(1)) == LAST);
                end
                default: begin
                    state <= IDLE;
                    r     <= '0;
                    p     <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_odo_round_sequencer.sv
// tb_odo_round_sequencer: directed bench for the round sequencer driving a behavioural key ROM.
module tb_odo_round_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [11:0] key;
    int n_pass = 0;
    int n_total = 0;
    int acc;
    localparam logic [11:0] KEYS [16] = '{12'h3ef, 12'h2d9, 12'h2d7, 12'h229, 12'h008,
                                           12'h335, 12'h091, 12'h073, 12'h1ce, 12'h1c6,
                                           12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
    odo_round_sequencer_if #(.RIDX_W(7)) bus ();
    odo_round_sequencer #(.NUM_ROUNDS(84), .KEY_PERIOD(10), .RIDX_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    always_ff @(posedge clk) key <= KEYS[bus.period];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic launch();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
    endtask
    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("done_seen", bus.done, 1);
        tick();
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_valid"}, bus.round_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_idx"}, bus.round_idx, 0);
        check({tag, "_last"}, bus.round_last, 0);
        check({tag, "_period"}, bus.period, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.dp_ready = 1'b0;
        #1;
        check_idle("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("post_rst");
        // full job, dp_ready held high
        bus.dp_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("prime_busy", bus.busy, 1);
        check("prime_valid", bus.round_valid, 0);
        check("prime_period", bus.period, 0);
        tick();
        for (int i = 0; i < 84; i++) begin
            check("full_valid", bus.round_valid, 1);
            check("full_idx", bus.round_idx, i);
            check("full_key", key, KEYS[i % 10]);
            check("full_last", bus.round_last, (i == 83) ? 1 : 0);
            tick();
        end
        check("full_done", bus.done, 1);
        check("full_done_busy", bus.busy, 1);
        check("full_done_valid", bus.round_valid, 0);
        tick();
        check("full_after_done", bus.done, 0);
        check("full_after_busy", bus.busy, 0);
        // stall at round 9
        launch();
        repeat (9) tick();
        bus.dp_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_idx", bus.round_idx, 9);
            check("stall_key", key, 12'h1c6);
            check("stall_period", bus.period, 9);
            tick();
        end
        bus.dp_ready = 1'b1;
        #1;
        check("release_period", bus.period, 0);
        tick();
        check("release_idx", bus.round_idx, 10);
        check("release_key", key, 12'h3ef);
        check("release_valid", bus.round_valid, 1);
        wait_done();
        // random backpressure with a round scoreboard
        acc = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 1000 && bus.done !== 1'b1; n++) begin
            bus.dp_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.round_valid && bus.dp_ready) begin
                check("rand_idx", bus.round_idx, acc);
                check("rand_key", key, KEYS[acc % 10]);
                acc++;
            end
            tick();
        end
        check("rand_done", bus.done, 1);
        check("rand_count", acc, 84);
        bus.dp_ready = 1'b1;
        tick();
        // abort at round 40
        launch();
        repeat (40) tick();
        check("abort_at_idx", bus.round_idx, 40);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_idle("abort");
        tick();
        check("abort_no_done", bus.done, 0);
        launch();
        check("restart_idx", bus.round_idx, 0);
        check("restart_key", key, 12'h3ef);
        check("restart_valid", bus.round_valid, 1);
        tick();
        // start pulses while busy are ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_start_idx", bus.round_idx, 2);
        repeat (81) tick();
        check("busy_start_last", bus.round_last, 1);
        tick();
        check("busy_start_done", bus.done, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("done_start_busy", bus.busy, 0);
        tick();
        check("done_start_not_queued", bus.busy, 0);
        launch();
        check("relaunch_valid", bus.round_valid, 1);
        check("relaunch_idx", bus.round_idx, 0);
        repeat (20) tick();
        check("mid_reset_idx", bus.round_idx, 20);
        // asynchronous reset mid-job
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_async_busy", bus.busy, 0);
            check("post_async_done", bus.done, 0);
            check("post_async_valid", bus.round_valid, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
